datapath_divisor: RTL and testbench

//  Datapath side of the divider control interface: executes the selA/wrA/wrB/aluOp

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_core.sv | 144 ++++++++++++++
 rtl/datapath_divisor.sv | 103 ++++++++++
 tb/tb_datapath_divisor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared encodings for the divider datapath: display-select
//               opcodes, engine state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Display select encodings driven by the control FSM on aluOp
  localparam logic [1:0] OP_SHOW_A = 2'b00;
  localparam logic [1:0] OP_SHOW_B = 2'b01;
  localparam logic [1:0] OP_SHOW_Q = 2'b10;
  localparam logic [1:0] OP_SHOW_R = 2'b11;

  // Iterative engine states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div_core.sv
// ============================================================================
// Module      : div_core
// Description : Iterative unsigned restoring divider, one quotient bit per
//               clock. Q/R are committed only on the CALC -> DONE transition.
//               Optional macro DIVZERO_DETECT_EN: a zero divisor at start
//               skips CALC and flags divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_core
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  // Next-cycle views so the registered display mux tracks Q/R/busy exactly
  output logic [WIDTH-1:0] o_q_nxt,
  output logic [WIDTH-1:0] o_r_nxt,
  output logic             o_busy_nxt
);

  localparam int             c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]  r_p, w_p_nxt;       // remainder after restore, always < divisor
  logic [WIDTH-1:0]  r_dvd, w_dvd_nxt;   // dividend shifts out MSB, quotient bits shift in LSB
  logic [WIDTH-1:0]  r_div, w_div_nxt;   // divisor captured at start
  logic [WIDTH-1:0]  r_q, w_q_nxt;
  logic [WIDTH-1:0]  r_r, w_r_nxt;
  logic              r_dz, w_dz_nxt;

  logic [WIDTH:0]    w_shift;            // WIDTH+1 bit partial remainder
  logic              w_ge;
  logic [WIDTH-1:0]  w_diff;
  logic [WIDTH-1:0]  w_rem;

  // One restoring step: shift in dividend MSB, subtract divisor if it fits
  always_comb begin
    w_shift = {r_p, r_dvd[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_div});
    // True difference is below 2^WIDTH whenever w_ge holds
    w_diff  = w_shift[WIDTH-1:0] - r_div;
    w_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
  end

  // Next-state and datapath update; a write always wins and parks the engine
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_p_nxt     = r_p;
    w_dvd_nxt   = r_dvd;
    w_div_nxt   = r_div;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_dz_nxt    = r_dz;

    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_dz_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
`ifdef DIVZERO_DETECT_EN
            if (i_b == '0) begin
              w_state_nxt = ST_DONE;
              w_q_nxt     = '1;
              w_r_nxt     = i_a;
              w_dz_nxt    = 1'b1;
            end else begin
`else
            begin
`endif
              w_state_nxt = ST_CALC;
              w_cnt_nxt   = '0;
              w_p_nxt     = '0;
              w_dvd_nxt   = i_a;
              w_div_nxt   = i_b;
            end
          end
        end
        ST_CALC: begin
          w_p_nxt   = w_rem;
          w_dvd_nxt = {r_dvd[WIDTH-2:0], w_ge};
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            w_state_nxt = ST_DONE;
            w_q_nxt     = {r_dvd[WIDTH-2:0], w_ge};
            w_r_nxt     = w_rem;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_dvd   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_p     <= w_p_nxt;
      r_dvd   <= w_dvd_nxt;
      r_div   <= w_div_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  assign o_q        = r_q;
  assign o_r        = r_r;
  assign o_busy     = (r_state == ST_CALC);
  assign o_done     = (r_state == ST_DONE);
  assign o_div_zero = r_dz;
  assign o_q_nxt    = w_q_nxt;
  assign o_r_nxt    = w_r_nxt;
  assign o_busy_nxt = (w_state_nxt == ST_CALC);

endmodule

`default_nettype wire

// File: rtl/datapath_divisor.sv
// ============================================================================
// Module      : datapath_divisor
// Description : Divider datapath: operand registers A/B, write-enable falling
//               edge detector that starts the iterative engine, and the
//               registered display mux. Optional macro DIVZERO_DETECT_EN
//               enables divide-by-zero short-circuit and the divZero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_divisor
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             selA,
  input  logic             wrA,
  input  logic             wrB,
  input  logic [1:0]       aluOp,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic             r_wr_d;
  logic             w_wr, w_start;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_result_nxt;
  logic [WIDTH-1:0] w_q, w_r, w_q_nxt, w_r_nxt;
  logic             w_busy, w_done, w_dz, w_busy_nxt;

  assign w_wr    = wrA | wrB;
  // Engine starts on the first quiet edge after a write
  assign w_start = r_wr_d & ~w_wr;

  assign w_a_nxt = wrA ? (selA ? dataA : w_r) : r_a;
  assign w_b_nxt = wrB ? dataB : r_b;

  div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clock),
    .rst        (reset),
    .i_start    (w_start),
    .i_abort    (w_wr),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_q        (w_q),
    .o_r        (w_r),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_div_zero (w_dz),
    .o_q_nxt    (w_q_nxt),
    .o_r_nxt    (w_r_nxt),
    .o_busy_nxt (w_busy_nxt)
  );

  // Display mux on next-cycle values so result matches the registers it shows
  always_comb begin
    w_result_nxt = '0;
    case (aluOp)
      OP_SHOW_A: w_result_nxt = w_a_nxt;
      OP_SHOW_B: w_result_nxt = w_b_nxt;
      OP_SHOW_Q: w_result_nxt = w_busy_nxt ? '0 : w_q_nxt;
      OP_SHOW_R: w_result_nxt = w_busy_nxt ? '0 : w_r_nxt;
      default:   w_result_nxt = '0;
    endcase
  end

  // Operand registers, write-enable history and display register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_wr_d   <= 1'b0;
      r_result <= '0;
    end else begin
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_wr_d   <= w_wr;
      r_result <= w_result_nxt;
    end
  end

  assign result = r_result;
  assign busy   = w_busy;
  assign done   = w_done;
`ifdef DIVZERO_DETECT_EN
  assign divZero = w_dz;
`else
  assign divZero = 1'b0;
  logic w_unused_dz;
  assign w_unused_dz = w_dz;
`endif

endmodule

`default_nettype wire

// File: tb/tb_datapath_divisor.sv
`default_nettype none

module tb_datapath_divisor;

  localparam int W = 4;

`ifdef DIVZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         selA, wrA, wrB;
  logic [1:0]   aluOp;
  logic [W-1:0] dataA, dataB;
  logic [W-1:0] result;
  logic         busy, done, divZero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic [7:0]   lat;
    logic [7:0]   bcyc;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] prev_q;

  datapath_divisor #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .selA    (selA),
    .wrA     (wrA),
    .wrB     (wrB),
    .aluOp   (aluOp),
    .dataA   (dataA),
    .dataB   (dataB),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .divZero (divZero)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model of the division, derived from the arithmetic definition
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.dz   = DZ_EN && (b == '0);
    e.lat  = (DZ_EN && b == '0) ? 8'd1 : 8'(W + 1);
    e.bcyc = (DZ_EN && b == '0) ? 8'd0 : 8'(W);
    return e;
  endfunction

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit sel, input bit wa, input bit wb, input int n);
    selA  = sel;
    wrA   = wa;
    wrB   = wb;
    dataA = a;
    dataB = b;
    repeat (n) tick();
    wrA  = 1'b0;
    wrB  = 1'b0;
    selA = 1'b0;
  endtask

  // Run edges until done, bounded; report latency, busy cycles and any nonzero Q display while busy
  task automatic wait_done(output int edges, output int bcyc, output int disp_bad);
    edges = 0; bcyc = 0; disp_bad = 0;
    while (edges < 40) begin
      tick();
      edges++;
      if (busy) begin
        bcyc++;
        if (result !== '0) disp_bad++;
      end
      if (done) break;
    end
  endtask

  task automatic show(input logic [1:0] op, output logic [W-1:0] v);
    aluOp = op;
    tick();
    v = result;
  endtask

  // Wait for a completion and check it against the scoreboard head
  task automatic check_completion(input string name);
    int edges, bcyc, bad;
    exp_t e;
    logic [W-1:0] v;
    aluOp = 2'b10;
    wait_done(edges, bcyc, bad);
    e = sb.pop_front();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL %s timeout: done=%b after %0d edges, required 1", name, done, edges);
    end
    n_tests++;
    if (edges !== int'(e.lat)) begin
      n_fail++; $display("FAIL %s latency: got %0d edges, required %0d", name, edges, e.lat);
    end
    n_tests++;
    if (bcyc !== int'(e.bcyc)) begin
      n_fail++; $display("FAIL %s busy cycles: got %0d, required %0d", name, bcyc, e.bcyc);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL %s display while busy: %0d nonzero samples, required 0", name, bad);
    end
    n_tests++;
    if (result !== e.q) begin
      n_fail++; $display("FAIL %s Q: got %0d, required %0d", name, result, e.q);
    end
    n_tests++;
    if (divZero !== e.dz) begin
      n_fail++; $display("FAIL %s divZero: got %b, required %b", name, divZero, e.dz);
    end
    show(2'b11, v);
    n_tests++;
    if (v !== e.r) begin
      n_fail++; $display("FAIL %s R: got %0d, required %0d", name, v, e.r);
    end
    prev_q = e.q;
    aluOp = 2'b10;
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    reset = 1'b1;
    selA = 0; wrA = 0; wrB = 0; aluOp = 2'b00; dataA = '0; dataB = '0;
    repeat (2) tick();
    reset = 1'b0;
    n_tests++;
    if ({busy, done, divZero} !== 3'b000 || result !== '0) begin
      n_fail++; $display("FAIL reset outputs: busy=%b done=%b divZero=%b result=%0d, required all 0", busy, done, divZero, result);
    end
    for (int op = 0; op < 4; op++) begin
      show(op[1:0], v);
      n_tests++;
      if (v !== '0) begin
        n_fail++; $display("FAIL reset reg op%0d: got %0d, required 0", op, v);
      end
    end
    prev_q = '0;
  endtask

  task automatic test_basic();
    logic [W-1:0] v;
    load(4'd13, 4'd4, 1'b1, 1'b1, 1'b1, 3);
    sb.push_back(model(4'd13, 4'd4));
    check_completion("basic_13_4");
    show(2'b00, v);
    n_tests++;
    if (v !== 4'd13) begin
      n_fail++; $display("FAIL basic show A: got %0d, required 13", v);
    end
    show(2'b01, v);
    n_tests++;
    if (v !== 4'd4) begin
      n_fail++; $display("FAIL basic show B: got %0d, required 4", v);
    end
  endtask

  task automatic test_chain();
    logic [W-1:0] v;
    aluOp = 2'b10;
    load(4'd9, 4'd0, 1'b0, 1'b1, 1'b0, 1);
    n_tests++;
    if (result !== prev_q || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL chain idle display: result=%0d done=%b busy=%b, required %0d/0/0", result, done, busy, prev_q);
    end
    sb.push_back(model(4'd1, 4'd4));
    check_completion("chain_R_over_4");
    show(2'b00, v);
    n_tests++;
    if (v !== 4'd1) begin
      n_fail++; $display("FAIL chain A from R: got %0d, required 1", v);
    end
  endtask

  task automatic test_divzero();
    load(4'd7, 4'd0, 1'b1, 1'b1, 1'b1, 2);
    n_tests++;
    if (divZero !== 1'b0) begin
      n_fail++; $display("FAIL divzero cleared by write: got %b, required 0", divZero);
    end
    sb.push_back(model(4'd7, 4'd0));
    check_completion("divzero_7_0");
  endtask

  task automatic test_boundary();
    logic [W-1:0] ta[3] = '{4'd0, 4'd15, 4'd5};
    logic [W-1:0] tb[3] = '{4'd5, 4'd1, 4'd15};
    for (int i = 0; i < 3; i++) begin
      load(ta[i], tb[i], 1'b1, 1'b1, 1'b1, 1);
      sb.push_back(model(ta[i], tb[i]));
      check_completion($sformatf("boundary_%0d_%0d", ta[i], tb[i]));
    end
  endtask

  task automatic test_abort();
    aluOp = 2'b10;
    load(4'd13, 4'd4, 1'b1, 1'b1, 1'b1, 3);
    sb.push_back(model(4'd13, 4'd4));
    tick();
    tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL abort precondition busy: got %b, required 1", busy);
    end
    wrB = 1'b1; dataB = 4'd2;
    tick();
    void'(sb.pop_back());
    sb.push_back(model(4'd13, 4'd2));
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== prev_q) begin
      n_fail++; $display("FAIL abort state: busy=%b done=%b result=%0d, required 0/0/%0d", busy, done, result, prev_q);
    end
    wrB = 1'b0;
    check_completion("abort_restart_13_2");
  endtask

  task automatic test_reset_mid();
    int seen;
    logic [W-1:0] v;
    aluOp = 2'b00;
    load(4'd13, 4'd4, 1'b1, 1'b1, 1'b1, 1);
    sb.push_back(model(4'd13, 4'd4));
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, divZero} !== 3'b000 || result !== '0) begin
      n_fail++; $display("FAIL reset mid-calc: busy=%b done=%b divZero=%b result=%0d, required all 0", busy, done, divZero, result);
    end
    void'(sb.pop_back());
    #2 reset = 1'b0;
    aluOp = 2'b10;
    seen = 0;
    repeat (6) begin
      tick();
      if (busy || done) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset engine idle: %0d active samples, required 0", seen);
    end
    show(2'b00, v);
    n_tests++;
    if (v !== '0) begin
      n_fail++; $display("FAIL reset mid A: got %0d, required 0", v);
    end
    prev_q = '0;
    load(4'd9, 4'd2, 1'b1, 1'b1, 1'b1, 1);
    sb.push_back(model(4'd9, 4'd2));
    check_completion("after_reset_9_2");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chain();
    test_divzero();
    test_boundary();
    test_abort();
    test_reset_mid();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
